// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive path (unstuffer, CRC checker).
package usb_rx_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRecv,
      StDone
   } rx_state_e;

   // Idle line level after SYNC; NRZI decoding restarts from here each packet.
   localparam logic J_LEVEL = 1'b1;

   localparam int unsigned DefStuffLimit = 6;
   localparam int unsigned DefMaxBytes   = 64;

endpackage

// File: rtl/nrzi_unstuff_bit.sv
// NRZI decode plus consecutive-ones tracking; flags data bits and stuff-bit violations.
module nrzi_unstuff_bit
   import usb_rx_pkg::*;
#(
   parameter int unsigned STUFF_LIMIT = DefStuffLimit
) (
   input  logic clock,
   input  logic reset_n,
   input  logic restart,
   input  logic bit_en,
   input  logic in_bit,
   output logic data_strobe,
   output logic data_bit,
   output logic stuff_viol
);

   localparam int unsigned OnesW = $clog2(STUFF_LIMIT + 1);

   logic             prev_level_q, prev_level_d, prev_base;
   logic [OnesW-1:0] ones_q, ones_d, ones_base;
   logic             decoded;

   // restart lets the first bit of a packet decode against J with a fresh ones count.
   always_comb begin
      prev_base    = restart ? J_LEVEL : prev_level_q;
      ones_base    = restart ? '0 : ones_q;
      decoded      = (in_bit == prev_base);
      prev_level_d = prev_level_q;
      ones_d       = ones_q;
      data_strobe  = 1'b0;
      data_bit     = decoded;
      stuff_viol   = 1'b0;
      if (bit_en) begin
         prev_level_d = in_bit;
         if (ones_base == OnesW'(STUFF_LIMIT)) begin
            ones_d     = '0;
            stuff_viol = decoded;
         end else begin
            data_strobe = 1'b1;
            ones_d      = decoded ? ones_base + OnesW'(1) : '0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         prev_level_q <= J_LEVEL;
         ones_q       <= '0;
      end else begin
         prev_level_q <= prev_level_d;
         ones_q       <= ones_d;
      end
   end

endmodule

// File: rtl/usb_rx_unstuff.sv
// USB receive stage: NRZI decode, bit unstuffing and LSB-first byte assembly with
// per-packet byte count and sticky error flags.
module usb_rx_unstuff
   import usb_rx_pkg::*;
#(
   parameter int unsigned STUFF_LIMIT = DefStuffLimit,
   parameter int unsigned MAX_BYTES   = DefMaxBytes
) (
   input  logic                             clock,
   input  logic                             reset_n,
   input  logic                             in_bit,
   input  logic                             in_valid,
   input  logic                             eop,
   output logic [7:0]                       data_byte,
   output logic                             byte_valid,
   output logic [$clog2(MAX_BYTES+1)-1:0]   byte_count,
   output logic                             pkt_done,
   output logic                             stuff_err,
   output logic                             align_err,
   output logic                             ovf_err
);

   localparam int unsigned CntW = $clog2(MAX_BYTES + 1);

   rx_state_e       state_q, state_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      data_byte_q, data_byte_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [CntW-1:0] byte_count_q, byte_count_d;
   logic            byte_valid_q, byte_valid_d;
   logic            pkt_done_q, pkt_done_d;
   logic            stuff_err_q, stuff_err_d;
   logic            align_err_q, align_err_d;
   logic            ovf_err_q, ovf_err_d;

   logic start, bit_en, data_strobe, data_bit, stuff_viol;

   assign start  = (state_q == StIdle) && in_valid;
   // A bit arriving together with eop is not part of the packet.
   assign bit_en = start || ((state_q == StRecv) && in_valid && !eop);

   nrzi_unstuff_bit #(
      .STUFF_LIMIT(STUFF_LIMIT)
   ) u_bit (
      .clock      (clock),
      .reset_n    (reset_n),
      .restart    (start),
      .bit_en     (bit_en),
      .in_bit     (in_bit),
      .data_strobe(data_strobe),
      .data_bit   (data_bit),
      .stuff_viol (stuff_viol)
   );

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      data_byte_d  = data_byte_q;
      bit_cnt_d    = bit_cnt_q;
      byte_count_d = byte_count_q;
      byte_valid_d = 1'b0;
      pkt_done_d   = 1'b0;
      stuff_err_d  = stuff_err_q;
      align_err_d  = align_err_q;
      ovf_err_d    = ovf_err_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               state_d      = StRecv;
               bit_cnt_d    = '0;
               byte_count_d = '0;
               stuff_err_d  = 1'b0;
               align_err_d  = 1'b0;
               ovf_err_d    = 1'b0;
            end
         end
         StRecv: begin
            if (eop) begin
               state_d    = StDone;
               pkt_done_d = 1'b1;
               bit_cnt_d  = '0;
               if (bit_cnt_q != 3'd0) align_err_d = 1'b1;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // Bit processing builds on the start-of-packet clears above.
      if (bit_en) begin
         if (stuff_viol) stuff_err_d = 1'b1;
         if (data_strobe) begin
            shift_d = {data_bit, shift_q[7:1]};
            if (bit_cnt_d == 3'd7) begin
               bit_cnt_d = '0;
               if (byte_count_d == CntW'(MAX_BYTES)) begin
                  ovf_err_d = 1'b1;
               end else begin
                  byte_count_d = byte_count_d + CntW'(1);
                  byte_valid_d = 1'b1;
                  data_byte_d  = shift_d;
               end
            end else begin
               bit_cnt_d = bit_cnt_d + 3'd1;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         shift_q      <= '0;
         data_byte_q  <= '0;
         bit_cnt_q    <= '0;
         byte_count_q <= '0;
         byte_valid_q <= 1'b0;
         pkt_done_q   <= 1'b0;
         stuff_err_q  <= 1'b0;
         align_err_q  <= 1'b0;
         ovf_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         data_byte_q  <= data_byte_d;
         bit_cnt_q    <= bit_cnt_d;
         byte_count_q <= byte_count_d;
         byte_valid_q <= byte_valid_d;
         pkt_done_q   <= pkt_done_d;
         stuff_err_q  <= stuff_err_d;
         align_err_q  <= align_err_d;
         ovf_err_q    <= ovf_err_d;
      end
   end

   assign data_byte  = data_byte_q;
   assign byte_valid = byte_valid_q;
   assign byte_count = byte_count_q;
   assign pkt_done   = pkt_done_q;
   assign stuff_err  = stuff_err_q;
   assign align_err  = align_err_q;
   assign ovf_err    = ovf_err_q;

endmodule

// File: tb/tb_usb_rx_unstuff.sv
// Bench for usb_rx_unstuff: directed scenarios plus randomized packets checked
// against a bit-list reference decoder.
module tb_usb_rx_unstuff;

   localparam int unsigned MaxBytes   = 2;
   localparam int unsigned StuffLimit = 6;
   localparam int unsigned CntW       = $clog2(MaxBytes + 1);

   logic            clock = 1'b0;
   logic            reset_n, in_bit, in_valid, eop;
   logic [7:0]      data_byte;
   logic            byte_valid, pkt_done, stuff_err, align_err, ovf_err;
   logic [CntW-1:0] byte_count;

   usb_rx_unstuff #(
      .STUFF_LIMIT(StuffLimit),
      .MAX_BYTES  (MaxBytes)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_bit    (in_bit),
      .in_valid  (in_valid),
      .eop       (eop),
      .data_byte (data_byte),
      .byte_valid(byte_valid),
      .byte_count(byte_count),
      .pkt_done  (pkt_done),
      .stuff_err (stuff_err),
      .align_err (align_err),
      .ovf_err   (ovf_err)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   logic       stim[$];
   logic [7:0] tx_bytes[$];
   logic [7:0] got_q[$];
   logic [7:0] exp_bytes[$];
   logic       exp_stuff, exp_align, exp_ovf;
   int         done_total = 0;
   int         clash_total = 0;
   int         got_base, done_base, clash_base;

   always @(negedge clock) begin
      if (byte_valid) got_q.push_back(data_byte);
      if (pkt_done) done_total <= done_total + 1;
      if (byte_valid && pkt_done) clash_total <= clash_total + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference decoder: walk the line levels as a list per the USB rules.
   task automatic model_run();
      int prev = 1;
      int ones = 0;
      int nbits = 0;
      int cur = 0;
      int d;
      exp_bytes.delete();
      exp_stuff = 1'b0;
      exp_ovf   = 1'b0;
      foreach (stim[i]) begin
         d    = (int'(stim[i]) == prev) ? 1 : 0;
         prev = int'(stim[i]);
         if (ones == StuffLimit) begin
            if (d == 1) exp_stuff = 1'b1;
            ones = 0;
         end else begin
            cur   = cur | (d << nbits);
            nbits = nbits + 1;
            ones  = (d == 1) ? ones + 1 : 0;
            if (nbits == 8) begin
               if (exp_bytes.size() == MaxBytes) exp_ovf = 1'b1;
               else exp_bytes.push_back(cur[7:0]);
               nbits = 0;
               cur   = 0;
            end
         end
      end
      exp_align = (nbits != 0);
   endtask

   // Byte list -> stuffed NRZI line levels, appended to stim.
   task automatic encode();
      logic level = 1'b1;
      int   ones  = 0;
      logic d;
      foreach (tx_bytes[i]) begin
         for (int k = 0; k < 8; k++) begin
            d = tx_bytes[i][k];
            if (!d) level = ~level;
            stim.push_back(level);
            ones = d ? ones + 1 : 0;
            if (ones == StuffLimit) begin
               level = ~level;
               stim.push_back(level);
               ones = 0;
            end
         end
      end
   endtask

   task automatic drive_bit(input logic b);
      @(posedge clock);
      #1;
      in_valid = 1'b1;
      in_bit   = b;
   endtask

   task automatic idle_cycle();
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      in_bit   = $urandom_range(0, 1);
   endtask

   task automatic drive_stim(input bit bubbles);
      foreach (stim[i]) begin
         if (bubbles && $urandom_range(0, 3) == 0) idle_cycle();
         drive_bit(stim[i]);
      end
   endtask

   task automatic begin_packet();
      got_base   = got_q.size();
      done_base  = done_total;
      clash_base = clash_total;
   endtask

   task automatic end_packet(input string name, input bit eop_bit);
      int ng;
      repeat ($urandom_range(1, 2)) idle_cycle();
      @(posedge clock);
      #1;
      eop      = 1'b1;
      in_valid = eop_bit;
      in_bit   = $urandom_range(0, 1);
      @(posedge clock);
      #1;
      eop      = 1'b0;
      in_valid = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      model_run();
      ng = got_q.size() - got_base;
      n_checks++;
      if (ng != exp_bytes.size()) begin
         n_fail++;
         $display("FAIL %s byte_valid pulses: got %0d want %0d", name, ng, exp_bytes.size());
      end
      foreach (exp_bytes[i]) begin
         if (i < ng) begin
            n_checks++;
            if (got_q[got_base+i] !== exp_bytes[i]) begin
               n_fail++;
               $display("FAIL %s data_byte[%0d]: got %02h want %02h", name, i,
                        got_q[got_base+i], exp_bytes[i]);
            end
         end
      end
      n_checks++;
      if (byte_count !== CntW'(exp_bytes.size())) begin
         n_fail++;
         $display("FAIL %s byte_count: got %0d want %0d", name, byte_count, exp_bytes.size());
      end
      n_checks++;
      if ({stuff_err, align_err, ovf_err} !== {exp_stuff, exp_align, exp_ovf}) begin
         n_fail++;
         $display("FAIL %s errors stuff/align/ovf: got %b%b%b want %b%b%b", name, stuff_err,
                  align_err, ovf_err, exp_stuff, exp_align, exp_ovf);
      end
      n_checks++;
      if (done_total - done_base != 1) begin
         n_fail++;
         $display("FAIL %s pkt_done pulses: got %0d want 1", name, done_total - done_base);
      end
      n_checks++;
      if (clash_total != clash_base) begin
         n_fail++;
         $display("FAIL %s byte_valid with pkt_done: got %0d want 0", name,
                  clash_total - clash_base);
      end
   endtask

   task automatic load_a5();
      stim = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_bit   = 1'b0;
      eop      = 1'b0;
      repeat (3) @(negedge clock);
      n_checks++;
      if ({data_byte, byte_valid, byte_count, pkt_done, stuff_err, align_err, ovf_err} !== '0)
      begin
         n_fail++;
         $display("FAIL reset outputs: byte=%02h bv=%b cnt=%0d pd=%b err=%b%b%b want all 0",
                  data_byte, byte_valid, byte_count, pkt_done, stuff_err, align_err, ovf_err);
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_eop_in_idle();
      begin_packet();
      @(posedge clock);
      #1;
      eop = 1'b1;
      @(posedge clock);
      #1;
      eop = 1'b0;
      repeat (3) @(negedge clock);
      n_checks++;
      if (done_total != done_base) begin
         n_fail++;
         $display("FAIL idle_eop pkt_done pulses: got %0d want 0", done_total - done_base);
      end
   endtask

   task automatic test_a5();
      load_a5();
      begin_packet();
      drive_stim(1'b0);
      @(negedge clock);
      n_checks++;
      if (byte_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL a5_latency early byte_valid: got %b want 0", byte_valid);
      end
      idle_cycle();
      @(negedge clock);
      n_checks++;
      if (byte_valid !== 1'b1 || data_byte !== 8'hA5) begin
         n_fail++;
         $display("FAIL a5_latency byte: bv=%b byte=%02h want bv=1 byte=a5", byte_valid,
                  data_byte);
      end
      end_packet("a5", 1'b0);
   endtask

   task automatic test_stuff_ff();
      stim = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      begin_packet();
      drive_stim(1'b0);
      end_packet("ff_stuffed", 1'b0);
      n_checks++;
      if (got_q.size() != got_base + 1 || got_q[got_base] !== 8'hFF || stuff_err !== 1'b0) begin
         n_fail++;
         $display("FAIL ff_stuffed direct: bytes=%0d stuff_err=%b want one ff, stuff_err 0",
                  got_q.size() - got_base, stuff_err);
      end
   endtask

   task automatic test_stuff_violation();
      stim = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      begin_packet();
      drive_stim(1'b0);
      @(negedge clock);
      n_checks++;
      if (stuff_err !== 1'b0) begin
         n_fail++;
         $display("FAIL stuff_viol early: got %b want 0", stuff_err);
      end
      idle_cycle();
      @(negedge clock);
      n_checks++;
      if (stuff_err !== 1'b1) begin
         n_fail++;
         $display("FAIL stuff_viol flag: got %b want 1", stuff_err);
      end
      end_packet("stuff_viol", 1'b0);
      // Flag must survive until the next packet's first bit.
      load_a5();
      begin_packet();
      drive_bit(stim[0]);
      idle_cycle();
      @(negedge clock);
      n_checks++;
      if (stuff_err !== 1'b0) begin
         n_fail++;
         $display("FAIL stuff_clear at packet start: got %b want 0", stuff_err);
      end
      for (int i = 1; i < 8; i++) drive_bit(stim[i]);
      end_packet("after_viol", 1'b0);
   endtask

   task automatic test_partial();
      load_a5();
      stim.push_back(1'b0);
      stim.push_back(1'b1);
      stim.push_back(1'b1);
      begin_packet();
      drive_stim(1'b1);
      end_packet("partial", 1'b0);
      n_checks++;
      if (align_err !== 1'b1 || byte_count !== CntW'(1)) begin
         n_fail++;
         $display("FAIL partial direct: align=%b cnt=%0d want align=1 cnt=1", align_err,
                  byte_count);
      end
   endtask

   task automatic test_overflow();
      stim.delete();
      for (int i = 0; i < 24; i++) stim.push_back(i[0]);
      begin_packet();
      drive_stim(1'b0);
      end_packet("overflow", 1'b1);
      n_checks++;
      if (got_q.size() != got_base + 2 || ovf_err !== 1'b1 || byte_count !== CntW'(2)) begin
         n_fail++;
         $display("FAIL overflow direct: bytes=%0d ovf=%b cnt=%0d want 2/1/2",
                  got_q.size() - got_base, ovf_err, byte_count);
      end
   endtask

   task automatic test_reset_mid();
      stim = '{1'b0, 1'b0, 1'b0, 1'b0};
      drive_stim(1'b0);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      reset_n  = 1'b0;
      #1;
      n_checks++;
      if ({data_byte, byte_valid, byte_count, pkt_done, stuff_err, align_err, ovf_err} !== '0)
      begin
         n_fail++;
         $display("FAIL reset_mid outputs: byte=%02h cnt=%0d err=%b%b%b want all 0", data_byte,
                  byte_count, stuff_err, align_err, ovf_err);
      end
      @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      load_a5();
      begin_packet();
      drive_stim(1'b0);
      end_packet("after_reset", 1'b0);
   endtask

   task automatic test_random();
      int nb, extra;
      for (int p = 0; p < 40; p++) begin
         stim.delete();
         if ($urandom_range(0, 2) != 0) begin
            tx_bytes.delete();
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
               case ($urandom_range(0, 3))
                  0: tx_bytes.push_back(8'hFF);
                  1: tx_bytes.push_back(8'hFE);
                  default: tx_bytes.push_back(8'($urandom));
               endcase
            end
            encode();
            extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            for (int e = 0; e < extra; e++) stim.push_back(1'($urandom));
         end else begin
            nb = $urandom_range(1, 30);
            for (int e = 0; e < nb; e++) stim.push_back($urandom_range(0, 3) != 0);
         end
         begin_packet();
         drive_stim($urandom_range(0, 1) == 1);
         end_packet($sformatf("rand%0d", p), $urandom_range(0, 1) == 1);
      end
   endtask

   initial begin
      test_reset();
      test_eop_in_idle();
      test_a5();
      test_stuff_ff();
      test_stuff_violation();
      test_partial();
      test_overflow();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
